// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants, datapath select encodings and the one-hot instruction class.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_NOP   = 6'h00;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_DM   = 2'b01;
  localparam logic [1:0] M2R_PC4  = 2'b10;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: opcode/funct to a one-hot instruction class.
module mc_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] Instr,
  output iclass_t     cls
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op    = Instr[31:26];
  assign funct = Instr[5:0];
  // Register and immediate fields play no part in classification.
  assign unused_fields = ^Instr[25:6];

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu    = 1'b1;
          FN_SUBU: cls.subu    = 1'b1;
          FN_JR:   cls.jr      = 1'b1;
          FN_NOP:  cls.nop     = 1'b1;
          default: cls.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with combinational strobe decode.
// Optional MC_CTRL_PERF_EN adds free-running cycle and retired-instruction counters.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  NPCOp,
  output logic [3:0]  ALUCtrl,
  output logic        ALUSrc,
  output logic [1:0]  ExtOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t  state;
  iclass_t cls;

  mc_decoder u_decoder (
    .Instr (Instr),
    .cls   (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= (cls.j || cls.jal || cls.jr || cls.nop || cls.illegal)
                           ? S_FETCH : S_EXEC;
        S_EXEC:   state <= (cls.lw || cls.sw) ? S_MEM : (cls.beq ? S_FETCH : S_WB);
        S_MEM:    state <= cls.lw ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Reset overrides the decode so no strobe escapes during an aborted instruction.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_PC4;
    ALUCtrl  = ALU_ADD;
    ALUSrc   = 1'b0;
    ExtOp    = EXT_ZERO;
    RegDst   = DST_RT;
    MemtoReg = M2R_ALU;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    if (!reset) begin
      // ALU set-up is held constant from EXEC through MEM and WB.
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        if (cls.subu || cls.beq)     ALUCtrl = ALU_SUB;
        else if (cls.ori || cls.lui) ALUCtrl = ALU_OR;
        ALUSrc = cls.ori || cls.lui || cls.lw || cls.sw;
        if (cls.lui)                ExtOp = EXT_LUI;
        else if (cls.lw || cls.sw)  ExtOp = EXT_SIGN;
      end
      case (state)
        S_FETCH: IRWrite = 1'b1;
        S_DECODE: begin
          if (cls.j || cls.jal) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_J;
          end else if (cls.jr) begin
            PCWrite = 1'b1;
            NPCOp   = NPC_JR;
          end else if (cls.nop || cls.illegal) begin
            PCWrite = 1'b1;
          end
          if (cls.jal) begin
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = M2R_PC4;
          end
        end
        S_EXEC: begin
          if (cls.beq) begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? NPC_BR : NPC_PC4;
          end
        end
        S_MEM: begin
          MemRead  = cls.lw;
          MemWrite = cls.sw;
          PCWrite  = cls.sw;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          RegDst   = (cls.addu || cls.subu) ? DST_RD : DST_RT;
          MemtoReg = cls.lw ? M2R_DM : M2R_ALU;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (PCWrite) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle strobe vectors for each instruction class.
// Perf counters are checked when MC_CTRL_PERF_EN is defined.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        IRWrite, PCWrite, ALUSrc, RegWrite, MemRead, MemWrite;
  logic [1:0]  NPCOp, ExtOp, RegDst, MemtoReg;
  logic [3:0]  ALUCtrl;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk      (clk),
    .reset    (reset),
    .Instr    (Instr),
    .Zero     (Zero),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .NPCOp    (NPCOp),
    .ALUCtrl  (ALUCtrl),
    .ALUSrc   (ALUSrc),
    .ExtOp    (ExtOp),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  // {IRWrite, PCWrite, NPCOp, ALUCtrl, ALUSrc, ExtOp, RegDst, MemtoReg, RegWrite, MemRead, MemWrite}
  logic [17:0] outs;
  assign outs = {IRWrite, PCWrite, NPCOp, ALUCtrl, ALUSrc, ExtOp, RegDst, MemtoReg,
                 RegWrite, MemRead, MemWrite};

  function automatic logic [17:0] ov(input logic irw, input logic pcw, input logic [1:0] npc,
                                     input logic [3:0] alu, input logic src,
                                     input logic [1:0] ext, input logic [1:0] dst,
                                     input logic [1:0] m2r, input logic rw,
                                     input logic mr, input logic mw);
    return {irw, pcw, npc, alu, src, ext, dst, m2r, rw, mr, mw};
  endfunction

  localparam logic [17:0] V_ZERO  = 18'h0;
  localparam logic [17:0] V_FETCH = 18'h20000;

  // Every task starts 1ns after a rising edge with the FSM in FETCH.
  task automatic test_reset();
    logic [17:0] exp_tail [4];
    reset = 1'b1;
    Instr = 32'h00221821;
    Zero  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (outs !== V_ZERO) begin
        bad++;
        $display("FAIL reset_hold cyc%0d got=%h want=%h", c, outs, V_ZERO);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    // addu up to EXEC, then reset for 3 cycles, then a clean addu
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (outs !== ((c == 0) ? V_FETCH : V_ZERO)) begin
        bad++;
        $display("FAIL reset_pre cyc%0d got=%h", c + 1, outs);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (outs !== V_ZERO) begin
        bad++;
        $display("FAIL reset_mid cyc%0d got=%h want=%h", c, outs, V_ZERO);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    exp_tail[0] = V_FETCH;
    exp_tail[1] = V_ZERO;
    exp_tail[2] = V_ZERO;
    exp_tail[3] = ov(0, 1, 2'b00, 4'd0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (outs !== exp_tail[c]) begin
        bad++;
        $display("FAIL reset_after cyc%0d got=%h want=%h", c + 1, outs, exp_tail[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [17:0] e [5];
    Instr = 32'h8C010004;
    e[0] = V_FETCH;
    e[1] = V_ZERO;
    e[2] = ov(0, 0, 2'b00, 4'd0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e[3] = ov(0, 0, 2'b00, 4'd0, 1, 2'b01, 2'b00, 2'b00, 0, 1, 0);
    e[4] = ov(0, 1, 2'b00, 4'd0, 1, 2'b01, 2'b00, 2'b01, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (outs !== e[c]) begin
        bad++;
        $display("FAIL lw cyc%0d got=%h want=%h", c + 1, outs, e[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [17:0] e [3];
    Instr = 32'h10220003;
    for (int z = 1; z >= 0; z--) begin
      Zero = z[0];
      e[0] = V_FETCH;
      e[1] = V_ZERO;
      e[2] = ov(0, 1, z[0] ? 2'b01 : 2'b00, 4'd1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        total++;
        if (outs !== e[c]) begin
          bad++;
          $display("FAIL beq_z%0d cyc%0d got=%h want=%h", z, c + 1, outs, e[c]);
        end
        @(posedge clk); #1;
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [31:0] ins [3];
    logic [17:0] dec [3];
    ins[0] = 32'h0C000010;
    dec[0] = ov(0, 1, 2'b10, 4'd0, 0, 2'b00, 2'b10, 2'b10, 1, 0, 0);
    ins[1] = 32'h08000010;
    dec[1] = ov(0, 1, 2'b10, 4'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    ins[2] = 32'h03E00008;
    dec[2] = ov(0, 1, 2'b11, 4'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      Instr = ins[k];
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        total++;
        if (outs !== ((c == 0) ? V_FETCH : dec[k])) begin
          bad++;
          $display("FAIL jump_%h cyc%0d got=%h", ins[k], c + 1, outs);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_nop_illegal();
    logic [31:0] ins [3];
    logic [17:0] dec;
    ins[0] = 32'hFC000000;
    ins[1] = 32'h00000000;
    ins[2] = 32'h0000003F;
    dec = ov(0, 1, 2'b00, 4'd0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      Instr = ins[k];
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        total++;
        if (outs !== ((c == 0) ? V_FETCH : dec)) begin
          bad++;
          $display("FAIL nopill_%h cyc%0d got=%h", ins[k], c + 1, outs);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Four-cycle instructions run back to back: subu, ori, lui, sw, addu.
  task automatic test_back_to_back();
    logic [31:0] ins [5];
    logic [17:0] e [5][4];
    ins[0] = 32'h00221823;
    e[0][2] = ov(0, 0, 2'b00, 4'd1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e[0][3] = ov(0, 1, 2'b00, 4'd1, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0);
    ins[1] = 32'h34210005;
    e[1][2] = ov(0, 0, 2'b00, 4'd2, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e[1][3] = ov(0, 1, 2'b00, 4'd2, 1, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    ins[2] = 32'h3C011234;
    e[2][2] = ov(0, 0, 2'b00, 4'd2, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    e[2][3] = ov(0, 1, 2'b00, 4'd2, 1, 2'b10, 2'b00, 2'b00, 1, 0, 0);
    ins[3] = 32'hAC010004;
    e[3][2] = ov(0, 0, 2'b00, 4'd0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e[3][3] = ov(0, 1, 2'b00, 4'd0, 1, 2'b01, 2'b00, 2'b00, 0, 0, 1);
    ins[4] = 32'h00221821;
    e[4][2] = V_ZERO;
    e[4][3] = ov(0, 1, 2'b00, 4'd0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      e[k][0] = V_FETCH;
      e[k][1] = V_ZERO;
      Instr = ins[k];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        total++;
        if (outs !== e[k][c]) begin
          bad++;
          $display("FAIL b2b_%h cyc%0d got=%h want=%h", ins[k], c + 1, outs, e[k][c]);
        end
        @(posedge clk); #1;
      end
    end
  endtask

`ifdef MC_CTRL_PERF_EN
  task automatic test_perf();
    logic [31:0] ins [3];
    int          len [3];
    ins[0] = 32'h00221821; len[0] = 4;
    ins[1] = 32'hAC010004; len[1] = 4;
    ins[2] = 32'h08000010; len[2] = 2;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_reset got=%0d/%0d want=0/0", cycle_cnt, instr_cnt);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Instr = ins[k];
      for (int c = 0; c < len[k]; c++) begin
        @(posedge clk); #1;
      end
    end
    total++;
    if (cycle_cnt !== 32'd10 || instr_cnt !== 32'd3) begin
      bad++;
      $display("FAIL perf_count cycle=%0d instr=%0d want 10/3", cycle_cnt, instr_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Instr = 32'h0;
    Zero  = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_beq();
    test_jumps();
    test_nop_illegal();
    test_back_to_back();
`ifdef MC_CTRL_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the MIPS core. It sits directly upstream of the datapath and drives all of the datapath's control strobes from a five-state machine. It decodes the latched instruction word and the ALU `Zero` flag. Each instruction spends 2–5 cycles; the PC is written exactly once per instruction, in that instruction's final state.

## Interface
- No parameters.
- `clk` in 1: system clock, all state updates on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `Instr` in 32: instruction register contents; valid from DECODE onward.
- `Zero` in 1: ALU zero flag, sampled combinationally in EXEC.
- `IRWrite` out 1: latch IM output into IR.
- `PCWrite` out 1: commit next PC.
- `NPCOp` out 2: next-PC source.
  - 00 = PC+4
  - 01 = PC+4+(sext(imm)<<2)
  - 10 = {PC[31:28], index, 00}
  - 11 = rs
- `ALUCtrl` out 4: ALU function. 0 = ADD, 1 = SUB, 2 = OR.
- `ALUSrc` out 1: ALU B source. 0 = rt, 1 = imm32.
- `ExtOp` out 2: immediate extension. 00 = zero, 01 = sign, 10 = imm<<16.
- `RegDst` out 2: write-register select. 00 = rt, 01 = rd, 10 = $31.
- `MemtoReg` out 2: write-back source. 00 = ALU, 01 = DM, 10 = PC+4.
- `RegWrite`, `MemRead`, `MemWrite` out 1 each: write/read strobes.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB.
- Outputs are a Moore/Mealy decode of (state, `Instr`, `Zero`). Any strobe not listed for a state is 0.
- FETCH: `IRWrite`=1 → DECODE.
- DECODE:
  - j: `PCWrite`=1, `NPCOp`=10 → FETCH.
  - jal: `PCWrite`=1, `NPCOp`=10, `RegWrite`=1, `RegDst`=10, `MemtoReg`=10 → FETCH.
  - jr: `PCWrite`=1, `NPCOp`=11 → FETCH.
  - nop/illegal: `PCWrite`=1, `NPCOp`=00 → FETCH.
  - All other instructions → EXEC.
- EXEC:
  - addu/subu: `ALUCtrl` ADD/SUB, `ALUSrc`=0 → WB.
  - ori: OR, `ALUSrc`=1, `ExtOp`=00 → WB.
  - lui: OR, `ALUSrc`=1, `ExtOp`=10 → WB.
  - lw/sw: ADD, `ALUSrc`=1, `ExtOp`=01 → MEM.
  - beq: SUB, `ALUSrc`=0, `PCWrite`=1, `NPCOp` = `Zero` ? 01 : 00 → FETCH.
- MEM: ALU controls are held from EXEC.
  - lw: `MemRead`=1 → WB.
  - sw: `MemWrite`=1, `PCWrite`=1, `NPCOp`=00 → FETCH.
- WB: ALU controls are held from EXEC; `RegWrite`=1, `PCWrite`=1, `NPCOp`=00.
  - R-type: `RegDst`=01, `MemtoReg`=00.
  - ori/lui: `RegDst`=00, `MemtoReg`=00.
  - lw: `RegDst`=00, `MemtoReg`=01.
  - WB → FETCH.
- Decode table (opcode op=Instr[31:26], funct=Instr[5:0]):
  - op 0: funct 0x21 addu, 0x23 subu, 0x08 jr, 0x00 nop.
  - op 0x0d ori, 0x0f lui, 0x23 lw, 0x2b sw, 0x04 beq, 0x02 j, 0x03 jal.
  - Anything else is illegal.

## Timing
- Reset:
  - While `reset`=1, every output is forced to 0, including `IRWrite`.
  - The next state is FETCH.
  - Reset asserted mid-instruction aborts that instruction; no `PCWrite`/`RegWrite`/`MemWrite` is issued in the cycle reset is high.
- Cycles per instruction:
  - j, jal, jr, nop, illegal: 2.
  - beq: 3.
  - addu, subu, ori, lui, sw: 4.
  - lw: 5.
- Exactly one `PCWrite` pulse per instruction, in its last cycle.
- `IRWrite` is high only in FETCH; `Instr` is stable from DECODE until the next FETCH edge.
- beq uses `Zero` from the same EXEC cycle, so there is no extra latency.
- jal: `RegWrite` and `PCWrite` share one edge. The datapath must use the pre-update PC+4 as write data.

## Configuration
- `MC_CTRL_PERF_EN` defined adds two outputs, both cleared by `reset`. Both wrap modulo 2^32.
  - `cycle_cnt` out 32: increments every non-reset cycle.
  - `instr_cnt` out 32: increments on every `PCWrite`.
- `MC_CTRL_PERF_EN` undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encoding;
  - opcode/funct constants;
  - `ALUCtrl`, `ExtOp`, `RegDst`, `MemtoReg` and `NPCOp` encodings.
- Sub-module `mc_decoder` (combinational): maps `Instr` to one-hot instruction class {addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop, illegal}.
- The top level holds only the FSM and the output decode.

## Test plan
- Reset held 3 cycles mid-EXEC of addu → all outputs 0 during reset; FETCH with `IRWrite`=1 on the first cycle after release.
- lw 0x8C010004 → `IRWrite` in cycle 1; EXEC with ALU ADD, `ExtOp`=01, `ALUSrc`=1; `MemRead` in cycle 4; cycle 5 has `RegWrite`=1, `MemtoReg`=01, `RegDst`=00, `PCWrite`=1, `NPCOp`=00.
- beq 0x10220003 with `Zero`=1 → cycle 3 `PCWrite`=1, `NPCOp`=01. With `Zero`=0 → `NPCOp`=00. Either way FETCH follows.
- jal 0x0C000010 → cycle 2 asserts `PCWrite`, `NPCOp`=10, `RegWrite`, `RegDst`=10, `MemtoReg`=10 together.
- Illegal 0xFC000000 and nop 0x00000000 → 2 cycles each; only `PCWrite` with `NPCOp`=00; no `RegWrite`/`MemWrite`.
- `MC_CTRL_PERF_EN`: run sequence addu, sw, j (4+4+2 cycles) → `instr_cnt`=3, `cycle_cnt`=10 after the final `PCWrite` edge.
